uart_alu_frame: RTL and testbench

//  Command engine downstream of the UART byte stream. Consumes received bytes over AXI-Stream.

---
 rtl/uart_alu_pkg.sv | 28 ++
 rtl/uart_alu_accum.sv | 68 ++++++
 rtl/uart_alu_frame.sv | 170 +++++++++++++++++
 tb/tb_uart_alu_frame.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU command engine.
// UART_ALU_MUL_EN decides whether MUL (0x88) is a recognised opcode.
package uart_alu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OPND_WIDTH_DEF = 32;
  localparam int HDR_BYTES      = 4;
  localparam int OPND_BYTES     = OPND_WIDTH_DEF / DATA_WIDTH_DEF;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hAD,
    OP_MUL  = 8'h88
  } opcode_e;

  typedef enum logic [2:0] {
    OPC, RSV, LENL, LENH, ECHO, OPND, RES, DRAIN
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
`ifdef UART_ALU_MUL_EN
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL);
`else
    return (op == OP_ECHO) || (op == OP_ADD);
`endif
  endfunction

endpackage

// File: rtl/uart_alu_accum.sv
// Operand shift register and accumulator; bytes arrive LSB-first.
// The multiplier exists only when UART_ALU_MUL_EN is defined.
module uart_alu_accum
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OPND_WIDTH = OPND_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data_byte,
  input  logic                  byte_valid,
  input  logic [7:0]            op,
  input  logic                  first,
  output logic [OPND_WIDTH-1:0] acc,
  output logic                  word_done
);

  localparam int NB = OPND_WIDTH / DATA_WIDTH;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [OPND_WIDTH-1:0] sr_q;
  logic [OPND_WIDTH-1:0] acc_q, acc_d;
  logic [OPND_WIDTH-1:0] word;
  logic [CW-1:0]         cnt_q;

  assign word      = {data_byte, sr_q[OPND_WIDTH-1:DATA_WIDTH]};
  assign word_done = byte_valid && (cnt_q == CW'(NB - 1));
  assign acc       = acc_q;

`ifdef UART_ALU_MUL_EN
  logic [OPND_WIDTH-1:0] prod;
  assign prod = acc_q * word;

  always_comb begin
    acc_d = acc_q;
    if (word_done) begin
      if (first)             acc_d = word;
      else if (op == OP_MUL) acc_d = prod;
      else                   acc_d = acc_q + word;
    end
  end
`else
  logic unused_op;
  assign unused_op = ^op;

  always_comb begin
    acc_d = acc_q;
    if (word_done) acc_d = first ? word : acc_q + word;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_ni || clr) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (byte_valid) begin
        sr_q  <= word;
        cnt_q <= word_done ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_alu_frame.sv
// Framed ALU command engine between UART RX and TX streams (ECHO/ADD, MUL under UART_ALU_MUL_EN).
// rst_ni is a synchronous ACTIVE-HIGH reset despite its name.
//   state | meaning
//   OPC   | wait for opcode byte
//   RSV   | reserved header byte
//   LENL  | length low byte
//   LENH  | length high byte, decide packet route
//   ECHO  | combinational pass-through of payload
//   OPND  | shift operands into accumulator
//   RES   | emit 4 result bytes
//   DRAIN | discard payload of a bad packet
module uart_alu_frame
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OPND_WIDTH = OPND_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  err_o
);

  localparam int IDX_W = (OPND_BYTES > 1) ? $clog2(OPND_BYTES) : 1;

  state_e                state_q, state_d;
  logic [15:0]           rem_q, rem_d;
  logic [DATA_WIDTH-1:0] len_lo_q;
  logic [7:0]            op_q;
  logic [IDX_W-1:0]      res_idx_q, res_idx_d;
  logic                  err_q, err_d;
  logic                  first_q;
  logic                  hdr_done, acc_byte_valid, word_done, s_fire, bad_len;
  logic [15:0]           len_full, len_pay;
  logic [OPND_WIDTH-1:0] acc;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign len_full = {s_axis_tdata, len_lo_q};
  assign len_pay  = len_full - 16'(HDR_BYTES);
  assign bad_len  = (len_full < 16'(HDR_BYTES)) ||
                    ((op_q != OP_ECHO) && ((len_pay % 16'(OPND_BYTES)) != '0));
  assign err_o    = err_q && !rst_ni;

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    res_idx_d      = res_idx_q;
    err_d          = 1'b0;
    hdr_done       = 1'b0;
    acc_byte_valid = 1'b0;
    s_axis_tready  = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    case (state_q)
      OPC: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = RSV;
      end
      RSV: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = LENL;
      end
      LENL: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = LENH;
      end
      LENH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          hdr_done = 1'b1;
          if (bad_len || !op_known(op_q)) begin
            err_d   = 1'b1;
            state_d = DRAIN;
            rem_d   = (len_full < 16'(HDR_BYTES)) ? '0 : len_pay;
          end else if (len_pay == '0) begin
            state_d = (op_q == OP_ECHO) ? OPC : RES;
          end else begin
            state_d = (op_q == OP_ECHO) ? ECHO : OPND;
            rem_d   = len_pay;
          end
        end
      end
      ECHO: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = OPC;
        end
      end
      OPND: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          acc_byte_valid = 1'b1;
          rem_d          = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = RES;
        end
      end
      RES: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = acc[res_idx_q*DATA_WIDTH +: DATA_WIDTH];
        if (m_axis_tready) begin
          res_idx_d = res_idx_q + 1'b1;
          if (res_idx_q == IDX_W'(OPND_BYTES - 1)) state_d = OPC;
        end
      end
      DRAIN: begin
        s_axis_tready = (rem_q != '0);
        if (rem_q == '0) begin
          state_d = OPC;
        end else if (s_axis_tvalid) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = OPC;
        end
      end
      default: state_d = OPC;
    endcase
    // Outputs read as idle during the reset cycle, whatever state is still held.
    if (rst_ni) begin
      s_axis_tready  = 1'b0;
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      acc_byte_valid = 1'b0;
      hdr_done       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q   <= OPC;
      rem_q     <= '0;
      len_lo_q  <= '0;
      op_q      <= '0;
      res_idx_q <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      res_idx_q <= res_idx_d;
      err_q     <= err_d;
      if (state_q == OPC && s_fire)  op_q     <= s_axis_tdata;
      if (state_q == LENL && s_fire) len_lo_q <= s_axis_tdata;
      if (hdr_done)       first_q <= 1'b1;
      else if (word_done) first_q <= 1'b0;
    end
  end

  uart_alu_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .OPND_WIDTH(OPND_WIDTH)
  ) u_accum (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr       (hdr_done),
    .data_byte (s_axis_tdata),
    .byte_valid(acc_byte_valid),
    .op        (op_q),
    .first     (first_q),
    .acc       (acc),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_uart_alu_frame.sv
// Scoreboard bench for uart_alu_frame; MUL expectations follow UART_ALU_MUL_EN.
module tb_uart_alu_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       err_o;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_base;
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = '0;
  bit         echo_chk = 1'b0;
  bit         echo_done;
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  uart_alu_frame dut (
    .clk_i        (clk),
    .rst_ni       (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .err_o        (err_o)
  );

  // Monitor: pops the scoreboard on every output transfer, checks AXI hold rule.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (err_o) err_seen++;
      if (hold_v) begin
        checks++;
        if (!m_tvalid || m_tdata !== hold_d) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h", m_tvalid, m_tdata, hold_d);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_byte: got unexpected %02h, required no output", m_tdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (m_tdata !== e) begin
            errors++;
            $display("FAIL out_byte: got %02h, required %02h", m_tdata, e);
          end
        end
      end
      if (echo_chk) begin
        checks++;
        if (s_tready !== m_tready) begin
          errors++;
          $display("FAIL echo_ready: s_tready=%0b, required %0b", s_tready, m_tready);
        end
      end
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (s_tready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h not accepted, required acceptance", b);
    end
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i]);
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic finish_pkt(input string name, input int exp_err);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_resp: %0d bytes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (err_seen - err_base != exp_err) begin
      errors++;
      $display("FAIL %s_err: %0d pulses, required %0d", name, err_seen - err_base, exp_err);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_s_tready", s_tready, 1'b0);
    check_bit("rst_m_tvalid", m_tvalid, 1'b0);
    checks++;
    if (m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_m_tdata: got %02h, required 00", m_tdata);
    end
    check_bit("rst_err", err_o, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_bit("idle_s_tready", s_tready, 1'b1);
    check_bit("idle_m_tvalid", m_tvalid, 1'b0);
    @(posedge clk);
    #1;

    // ADD
    err_base = err_seen;
    expect_word(32'h0000_0003);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    finish_pkt("add", 0);

    // ADD wrap
    err_base = err_seen;
    expect_word(32'h0000_0001);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    finish_pkt("add_wrap", 0);

    // MUL
    err_base = err_seen;
`ifdef UART_ALU_MUL_EN
    expect_word(32'h0000_000F);
`endif
    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
`ifdef UART_ALU_MUL_EN
    finish_pkt("mul", 0);
`else
    finish_pkt("mul", 1);
`endif

    // ECHO with m_tready toggling 1,0,0,1
    err_base = err_seen;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    echo_done = 1'b0;
    fork
      begin
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00};
        send_pkt();
        echo_chk = 1'b1;
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        echo_chk = 1'b0;
        echo_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!echo_done) begin
          m_tready = pat[k % 4];
          k++;
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    finish_pkt("echo", 0);

    // Malformed length then valid single-operand ADD
    err_base = err_seen;
    pkt = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    finish_pkt("malformed", 1);
    err_base = err_seen;
    expect_word(32'h0000_0007);
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt();
    finish_pkt("after_bad", 0);

    // LEN below header size, then ADD with LEN==4 (result 0), ECHO LEN==4 (no output)
    err_base = err_seen;
    pkt = '{8'hAD, 8'h00, 8'h03, 8'h00};
    send_pkt();
    finish_pkt("len_short", 1);
    err_base = err_seen;
    expect_word(32'h0000_0000);
    pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
    send_pkt();
    finish_pkt("add_len4", 0);
    err_base = err_seen;
    pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
    send_pkt();
    finish_pkt("echo_len4", 0);

    // Unknown opcode drains its payload
    err_base = err_seen;
    pkt = '{8'h55, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt();
    finish_pkt("bad_op", 1);

    // Reset in the middle of RES after two result bytes
    m_tready = 1'b0;
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h00);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
    send_pkt();
    m_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_bit("midrst_m_tvalid", m_tvalid, 1'b0);
    check_bit("midrst_s_tready", s_tready, 1'b0);
    checks++;
    if (m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL midrst_m_tdata: got %02h, required 00", m_tdata);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_bytes: %0d result bytes not sent, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    check_bit("postrst_m_tvalid", m_tvalid, 1'b0);
    @(posedge clk);
    #1;
    err_base = err_seen;
    expect_word(32'h0000_0009);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
    finish_pkt("post_reset_add", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
